// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bundle: instruction-memory request side plus the decode-facing valid/ready stream.
// master = fetch unit, slave = memory/decode environment.
interface instr_fetch_unit_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [DATA_WIDTH-1:0] imem_rdata;
    logic                  imem_req;
    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic                  halt;
    logic                  inst_valid;
    logic                  inst_ready;
    logic [DATA_WIDTH-1:0] inst_data;
    logic [ADDR_WIDTH-1:0] inst_pc;

    modport master (
        output imem_addr, imem_req, inst_valid, inst_data, inst_pc,
        input  imem_rdata, redirect_valid, redirect_pc, halt, inst_ready
    );

    modport slave (
        input  imem_addr, imem_req, inst_valid, inst_data, inst_pc,
        output imem_rdata, redirect_valid, redirect_pc, halt, inst_ready
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// PC + prefetch FIFO: one word fetched per cycle, visible to decode one cycle after capture; fetch stalls when full or halted.
// Redirect flushes and overrides all. IFU_PERF_CNT_EN adds perf_fetch_cnt / perf_stall_cnt outputs.
module instr_fetch_unit #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           FIFO_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int unsigned           PC_STEP    = 1
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef IFU_PERF_CNT_EN
    output logic [31:0]        perf_fetch_cnt,
    output logic [31:0]        perf_stall_cnt,
`endif
    instr_fetch_unit_if.master bus
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [ADDR_WIDTH-1:0] pc_mem_q  [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] pc_mem_d  [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] dat_mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] dat_mem_d [FIFO_DEPTH];

    logic empty, full, push, pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(FIFO_DEPTH));
    // rst_n gates the request so memory sees no fetch while reset is held.
    assign push  = rst_n & ~bus.redirect_valid & ~bus.halt & ~full;
    assign pop   = ~bus.redirect_valid & ~empty & bus.inst_ready;

    assign bus.imem_addr  = pc_q;
    assign bus.imem_req   = push;
    assign bus.inst_valid = ~empty;
    assign bus.inst_data  = empty ? '0 : dat_mem_q[rd_ptr_q];
    assign bus.inst_pc    = empty ? '0 : pc_mem_q[rd_ptr_q];

    always_comb begin
        pc_d      = pc_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        pc_mem_d  = pc_mem_q;
        dat_mem_d = dat_mem_q;
        if (bus.redirect_valid) begin
            pc_d     = bus.redirect_pc;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                pc_mem_d[wr_ptr_q]  = pc_q;
                dat_mem_d[wr_ptr_q] = bus.imem_rdata;
                wr_ptr_d            = wr_ptr_q + PTR_W'(1);
                pc_d                = pc_q + ADDR_WIDTH'(PC_STEP);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            pc_mem_q  <= '{default: '0};
            dat_mem_q <= '{default: '0};
        end else begin
            pc_q      <= pc_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            pc_mem_q  <= pc_mem_d;
            dat_mem_q <= dat_mem_d;
        end
    end

`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetch_q, perf_fetch_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_fetch_d = perf_fetch_q + 32'(push);
        perf_stall_d = perf_stall_q + 32'(empty & bus.inst_ready);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_q <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_stall_cnt = perf_stall_q;
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit; memory returns 32'hA5A5_0000 | addr[15:0].
module tb_instr_fetch_unit;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    instr_fetch_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    instr_fetch_unit #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .FIFO_DEPTH(4), .RESET_PC(32'h0), .PC_STEP(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
`ifdef IFU_PERF_CNT_EN
        .perf_fetch_cnt(perf_fetch_cnt),
        .perf_stall_cnt(perf_stall_cnt),
`endif
        .bus(bus)
    );

    assign bus.imem_rdata = 32'hA5A5_0000 | {16'h0, bus.imem_addr[15:0]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n              = 1'b0;
        bus.inst_ready     = 1'b0;
        bus.halt           = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n              = 1'b0;
        bus.inst_ready     = 1'b1;
        bus.halt           = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        step();
        step();
        total++; if (bus.inst_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", bus.inst_valid); end
        total++; if (bus.inst_data !== 32'h0) begin bad++; $display("FAIL rst_data got=%h exp=0", bus.inst_data); end
        total++; if (bus.inst_pc !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=0", bus.inst_pc); end
        total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", bus.imem_req); end
        total++; if (bus.imem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", bus.imem_addr); end
        rst_n = 1'b1;
        #1;
        total++; if (bus.imem_req !== 1'b1) begin bad++; $display("FAIL rel_req got=%b exp=1", bus.imem_req); end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        do_reset();
        bus.inst_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            exp_pc = i;
            total++; if (bus.inst_valid !== 1'b1) begin bad++; $display("FAIL stream_valid[%0d] got=%b exp=1", i, bus.inst_valid); end
            total++; if (bus.inst_pc !== exp_pc) begin bad++; $display("FAIL stream_pc[%0d] got=%h exp=%h", i, bus.inst_pc, exp_pc); end
            total++; if (bus.inst_data !== (32'hA5A5_0000 + exp_pc)) begin bad++; $display("FAIL stream_data[%0d] got=%h exp=%h", i, bus.inst_data, 32'hA5A5_0000 + exp_pc); end
        end
    endtask

    task automatic test_full();
        logic [31:0] exp_pc;
        do_reset();
        bus.inst_ready = 1'b0;
        for (int i = 0; i < 8; i++) step();
        total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL full_req got=%b exp=0", bus.imem_req); end
        total++; if (bus.imem_addr !== 32'd4) begin bad++; $display("FAIL full_addr got=%h exp=4", bus.imem_addr); end
        total++; if (bus.inst_pc !== 32'd0) begin bad++; $display("FAIL full_head got=%h exp=0", bus.inst_pc); end
        bus.inst_ready = 1'b1;
        step();
        total++; if (bus.imem_addr !== 32'd4) begin bad++; $display("FAIL full_pop_addr got=%h exp=4", bus.imem_addr); end
        total++; if (bus.imem_req !== 1'b1) begin bad++; $display("FAIL full_reopen_req got=%b exp=1", bus.imem_req); end
        for (int i = 1; i <= 5; i++) begin
            exp_pc = i;
            total++; if (bus.inst_pc !== exp_pc) begin bad++; $display("FAIL drain_pc[%0d] got=%h exp=%h", i, bus.inst_pc, exp_pc); end
            total++; if (bus.inst_data !== (32'hA5A5_0000 + exp_pc)) begin bad++; $display("FAIL drain_data[%0d] got=%h exp=%h", i, bus.inst_data, 32'hA5A5_0000 + exp_pc); end
            step();
        end
    endtask

    task automatic test_redirect();
        do_reset();
        bus.inst_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        bus.inst_ready = 1'b0;
        step();
        step();
        total++; if (bus.inst_pc !== 32'd5) begin bad++; $display("FAIL redir_pre_head got=%h exp=5", bus.inst_pc); end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h40;
        bus.inst_ready     = 1'b1;
        #1;
        total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL redir_req got=%b exp=0", bus.imem_req); end
        step();
        bus.redirect_valid = 1'b0;
        total++; if (bus.inst_valid !== 1'b0) begin bad++; $display("FAIL redir_flush_valid got=%b exp=0", bus.inst_valid); end
        total++; if (bus.imem_addr !== 32'h40) begin bad++; $display("FAIL redir_addr got=%h exp=40", bus.imem_addr); end
        step();
        total++; if (bus.inst_pc !== 32'h40) begin bad++; $display("FAIL redir_head_pc got=%h exp=40", bus.inst_pc); end
        total++; if (bus.inst_data !== 32'hA5A5_0040) begin bad++; $display("FAIL redir_head_data got=%h exp=a5a50040", bus.inst_data); end
        step();
        total++; if (bus.inst_pc !== 32'h41) begin bad++; $display("FAIL redir_next_pc got=%h exp=41", bus.inst_pc); end
    endtask

    task automatic test_halt();
        do_reset();
        bus.inst_ready = 1'b0;
        step(); step(); step();
        bus.halt       = 1'b1;
        bus.inst_ready = 1'b1;
        #1;
        total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL halt_req got=%b exp=0", bus.imem_req); end
        step();
        total++; if (bus.inst_pc !== 32'd1) begin bad++; $display("FAIL halt_pop1 got=%h exp=1", bus.inst_pc); end
        step();
        total++; if (bus.inst_pc !== 32'd2) begin bad++; $display("FAIL halt_pop2 got=%h exp=2", bus.inst_pc); end
        step();
        total++; if (bus.inst_valid !== 1'b0) begin bad++; $display("FAIL halt_empty got=%b exp=0", bus.inst_valid); end
        step();
        total++; if (bus.imem_addr !== 32'd3) begin bad++; $display("FAIL halt_pc_hold got=%h exp=3", bus.imem_addr); end
        total++; if (bus.inst_data !== 32'h0) begin bad++; $display("FAIL halt_empty_data got=%h exp=0", bus.inst_data); end
        bus.halt = 1'b0;
        step();
        total++; if (bus.inst_pc !== 32'd3) begin bad++; $display("FAIL halt_resume_pc got=%h exp=3", bus.inst_pc); end
        total++; if (bus.inst_data !== 32'hA5A5_0003) begin bad++; $display("FAIL halt_resume_data got=%h exp=a5a50003", bus.inst_data); end
    endtask

    task automatic test_wrap();
        do_reset();
        bus.inst_ready     = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFE;
        step();
        bus.redirect_valid = 1'b0;
        step();
        total++; if (bus.inst_pc !== 32'hFFFF_FFFE) begin bad++; $display("FAIL wrap_pc0 got=%h exp=fffffffe", bus.inst_pc); end
        total++; if (bus.inst_data !== 32'hA5A5_FFFE) begin bad++; $display("FAIL wrap_data0 got=%h exp=a5a5fffe", bus.inst_data); end
        step();
        total++; if (bus.inst_pc !== 32'hFFFF_FFFF) begin bad++; $display("FAIL wrap_pc1 got=%h exp=ffffffff", bus.inst_pc); end
        step();
        total++; if (bus.inst_pc !== 32'h0) begin bad++; $display("FAIL wrap_pc2 got=%h exp=0", bus.inst_pc); end
        total++; if (bus.inst_data !== 32'hA5A5_0000) begin bad++; $display("FAIL wrap_data2 got=%h exp=a5a50000", bus.inst_data); end
        step();
        total++; if (bus.inst_pc !== 32'h1) begin bad++; $display("FAIL wrap_pc3 got=%h exp=1", bus.inst_pc); end
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.inst_ready = 1'b1;
        step(); step(); step();
        total++; if (bus.inst_pc !== 32'd2) begin bad++; $display("FAIL arst_pre_pc got=%h exp=2", bus.inst_pc); end
`ifdef IFU_PERF_CNT_EN
        total++; if (perf_fetch_cnt !== 32'd3) begin bad++; $display("FAIL perf_fetch got=%0d exp=3", perf_fetch_cnt); end
        total++; if (perf_stall_cnt !== 32'd1) begin bad++; $display("FAIL perf_stall got=%0d exp=1", perf_stall_cnt); end
`endif
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (bus.inst_valid !== 1'b0) begin bad++; $display("FAIL arst_valid got=%b exp=0", bus.inst_valid); end
        total++; if (bus.imem_addr !== 32'h0) begin bad++; $display("FAIL arst_addr got=%h exp=0", bus.imem_addr); end
        total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL arst_req got=%b exp=0", bus.imem_req); end
`ifdef IFU_PERF_CNT_EN
        total++; if (perf_fetch_cnt !== 32'd0) begin bad++; $display("FAIL arst_perf_fetch got=%0d exp=0", perf_fetch_cnt); end
        total++; if (perf_stall_cnt !== 32'd0) begin bad++; $display("FAIL arst_perf_stall got=%0d exp=0", perf_stall_cnt); end
`endif
        step();
        #2;
        rst_n = 1'b1;
        step();
        total++; if (bus.inst_pc !== 32'd0) begin bad++; $display("FAIL arst_restart_pc got=%h exp=0", bus.inst_pc); end
        total++; if (bus.inst_valid !== 1'b1) begin bad++; $display("FAIL arst_restart_valid got=%b exp=1", bus.inst_valid); end
        step();
        total++; if (bus.inst_pc !== 32'd1) begin bad++; $display("FAIL arst_restart_pc1 got=%h exp=1", bus.inst_pc); end
    endtask

    initial begin
        total              = 0;
        bad                = 0;
        rst_n              = 1'b0;
        bus.inst_ready     = 1'b0;
        bus.halt           = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        test_reset();
        test_stream();
        test_full();
        test_redirect();
        test_halt();
        test_wrap();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
